// File: rtl/fe_sched_pipe.sv
// Forwarding engine: latency-hinted packets ride a shifting slot pipeline into an output FIFO.
// Occupied target slots make a packet slip upward; a full FIFO with slot 1 occupied stalls everything.
module fe_sched_pipe #(
  parameter int unsigned DW    = 128,
  parameter int unsigned LATW  = 2,
  parameter int unsigned SLACK = 2,
  parameter int unsigned OFD   = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CW    = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fwd_pkt_data_vld_i,
  input  logic [DW-1:0]   fwd_pkt_data_i,
  input  logic [LATW-1:0] fwd_pkt_lat_i,
  input  logic            fwd_pkt_dp_vld_i,
  input  logic [DW-1:0]   fwd_pkt_dp_data_i,
  output logic            fwd_pkt_rdy_o,
  output logic            fwded_pkt_data_vld_o,
  output logic [DW-1:0]   fwded_pkt_data_o,
  input  logic            fwded_pkt_rdy_i,
  output logic [CW-1:0]   slip_cnt_o,
  output logic [CW-1:0]   in_cnt_o,
  output logic [CW-1:0]   out_cnt_o
);

  localparam int unsigned NS  = 2**LATW + SLACK;
  localparam int unsigned SW  = $clog2(NS);
  localparam int unsigned PW  = (OFD > 1) ? $clog2(OFD) : 1;
  localparam int unsigned FCW = $clog2(OFD + 1);

  // Index i holds slot i+1; index 0 is the exit slot.
  logic [NS-1:0] slot_v_q, slot_v_d, post_v;
  logic [DW-1:0] slot_data_q [NS];
  logic [DW-1:0] slot_data_d [NS];

  logic [DW-1:0]  fifo_q [OFD];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]  slip_cnt_q, slip_cnt_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;

  logic          pop, push, adv, found, xfer, slip;
  logic [SW-1:0] sel;
  logic [DW-1:0] dp_eff, mix;

  assign pop    = (fifo_cnt_q != '0) && fwded_pkt_rdy_i;
  assign adv    = !slot_v_q[0] || (fifo_cnt_q < FCW'(OFD)) || pop;
  assign push   = adv && slot_v_q[0];
  assign post_v = {1'b0, slot_v_q[NS-1:1]};

  // Lowest free post-shift slot at or above the target.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NS; i++) begin
      if (!found && (i >= int'(fwd_pkt_lat_i)) && !post_v[i]) begin
        found = 1'b1;
        sel   = SW'(i);
      end
    end
  end

  assign fwd_pkt_rdy_o = adv && found;
  assign xfer          = fwd_pkt_data_vld_i && fwd_pkt_rdy_o;
  assign slip          = xfer && (sel != SW'(fwd_pkt_lat_i));
  assign dp_eff        = fwd_pkt_dp_vld_i ? fwd_pkt_dp_data_i : '0;
  assign mix           = (MODE == 0) ? (fwd_pkt_data_i + dp_eff) : (fwd_pkt_data_i ^ dp_eff);

  always_comb begin
    slot_v_d = slot_v_q;
    for (int i = 0; i < NS; i++) slot_data_d[i] = slot_data_q[i];
    if (adv) begin
      slot_v_d = post_v;
      for (int i = 0; i < NS - 1; i++) slot_data_d[i] = slot_data_q[i+1];
    end
    if (xfer) begin
      slot_v_d[sel]    = 1'b1;
      slot_data_d[sel] = mix;
    end
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OFD - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(OFD - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    in_cnt_d   = in_cnt_q + CW'(xfer);
    out_cnt_d  = out_cnt_q + CW'(pop);
    slip_cnt_d = slip_cnt_q + CW'(slip);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_v_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      slip_cnt_q <= '0;
    end else begin
      slot_v_q   <= slot_v_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  // Payload storage is qualified by the valid bits / count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NS; i++) slot_data_q[i] <= slot_data_d[i];
    if (push) fifo_q[wr_ptr_q] <= slot_data_q[0];
  end

  assign fwded_pkt_data_vld_o = (fifo_cnt_q != '0);
  assign fwded_pkt_data_o     = fwded_pkt_data_vld_o ? fifo_q[rd_ptr_q] : '0;
  assign slip_cnt_o           = slip_cnt_q;
  assign in_cnt_o             = in_cnt_q;
  assign out_cnt_o            = out_cnt_q;

endmodule

// File: tb/tb_fe_sched_pipe.sv
// Scoreboard bench for fe_sched_pipe: an add-mode and an xor-mode instance share one stimulus stream.
module tb_fe_sched_pipe;
  localparam int DW = 128;
  localparam int LATW = 2;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_vld, dp_vld, out_rdy;
  logic [DW-1:0]   in_data, dp_data;
  logic [LATW-1:0] in_lat;
  logic            rdy0, vld0, rdy1, vld1;
  logic [DW-1:0]   data0, data1;
  logic [CW-1:0]   slip0, inc0, outc0, slip1, inc1, outc1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fe_sched_pipe #(.MODE(0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fwd_pkt_data_vld_i(in_vld), .fwd_pkt_data_i(in_data), .fwd_pkt_lat_i(in_lat),
    .fwd_pkt_dp_vld_i(dp_vld), .fwd_pkt_dp_data_i(dp_data), .fwd_pkt_rdy_o(rdy0),
    .fwded_pkt_data_vld_o(vld0), .fwded_pkt_data_o(data0), .fwded_pkt_rdy_i(out_rdy),
    .slip_cnt_o(slip0), .in_cnt_o(inc0), .out_cnt_o(outc0)
  );

  fe_sched_pipe #(.MODE(1)) dut_x (
    .clk_i(clk), .rst_ni(rst_n),
    .fwd_pkt_data_vld_i(in_vld), .fwd_pkt_data_i(in_data), .fwd_pkt_lat_i(in_lat),
    .fwd_pkt_dp_vld_i(dp_vld), .fwd_pkt_dp_data_i(dp_data), .fwd_pkt_rdy_o(rdy1),
    .fwded_pkt_data_vld_o(vld1), .fwded_pkt_data_o(data1), .fwded_pkt_rdy_i(out_rdy),
    .slip_cnt_o(slip1), .in_cnt_o(inc1), .out_cnt_o(outc1)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop the expected entry whenever an output beat is taken.
  always @(negedge clk) begin
    if (vld0 && out_rdy) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %0h, expected no output (cycle %0d)", data0, cyc);
      end else begin
        e0 = q0.pop_front();
        chk("add_out_data", data0, e0.data);
        if (e0.cyc >= 0) chk("add_out_cycle", DW'(cyc), DW'(e0.cyc));
      end
    end
    if (vld1 && out_rdy) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_xor_out: got %0h, expected no output (cycle %0d)", data1, cyc);
      end else begin
        e1 = q1.pop_front();
        chk("xor_out_data", data1, e1.data);
      end
    end
  end

  // dly: expected acceptance-to-output latency in cycles, or -1 when not checked.
  task automatic send(input logic [DW-1:0] d, input logic dv, input logic [DW-1:0] dp,
                      input int lat, input int dly);
    int n = 0;
    in_vld = 1'b1; in_data = d; dp_vld = dv; dp_data = dp; in_lat = LATW'(lat);
    @(negedge clk);
    while (!rdy0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rdy0) begin
      checks++; errors++;
      $display("FAIL send_timeout: got rdy=0, expected rdy=1 within 200 cycles");
    end else begin
      q0.push_back('{data: d + (dv ? dp : '0), cyc: (dly >= 0) ? cyc + dly : -1});
      q1.push_back('{data: d ^ (dv ? dp : '0), cyc: -1});
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q0.size() + q1.size());
      q0.delete(); q1.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_vld = 1'b0; in_data = '0; dp_vld = 1'b0; dp_data = '0; in_lat = '0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", DW'(rdy0), 1);
    chk("reset_vld", DW'(vld0), 0);
    chk("reset_data", data0, 0);
    chk("reset_in_cnt", DW'(inc0), 0);
    rst_n = 1'b1;

    // 1) L=0, 5+3 -> 8, two cycles after acceptance
    while (cyc < 10) begin
      @(posedge clk); #1;
    end
    send(128'd5, 1'b1, 128'd3, 0, 2);
    drain();
    chk("t1_in_cnt", DW'(inc0), 1);
    chk("t1_out_cnt", DW'(outc0), 1);
    chk("t1_slip_cnt", DW'(slip0), 0);

    // 2) A(L=3) then B(L=2): same nominal exit, B slips one cycle; B's dp ignored
    do_reset();
    send(128'h11, 1'b1, 128'h22, 3, 5);
    send(128'h40, 1'b0, 128'hDEAD, 2, 5);
    drain();
    chk("t2_slip_cnt", DW'(slip0), 1);
    chk("t2_in_cnt", DW'(inc0), 2);

    // 4) mode mixing and add wrap
    do_reset();
    send(128'hF0, 1'b1, 128'hFF, 0, 2);
    send('1, 1'b1, 128'd1, 1, 3);
    drain();
    chk("t4_out_cnt", DW'(outc1), 2);

    // 3) output stalled: 5 accepted (4 in FIFO, 1 in slot 1), 6th blocked
    do_reset();
    out_rdy = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(DW'(100 + i), 1'b0, '0, 0, -1);
      begin
        repeat (12) @(negedge clk);
        chk("t3_stall_rdy", DW'(rdy0), 0);
        chk("t3_stall_in_cnt", DW'(inc0), 5);
        chk("t3_stall_vld", DW'(vld0), 1);
        chk("t3_head", data0, 100);
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    drain();
    chk("t3_in_cnt", DW'(inc0), 6);
    chk("t3_out_cnt", DW'(outc0), 6);

    // 5) slots full behind a full FIFO: L=2 held until release, then slips one slot
    do_reset();
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send(DW'(200 + i), 1'b1, DW'(i), 3, -1);
    fork
      send(128'h77, 1'b0, '0, 2, -1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t5_held_rdy", DW'(rdy0), 0);
        end
        chk("t5_held_in_cnt", DW'(inc0), 8);
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    drain();
    chk("t5_in_cnt", DW'(inc0), 9);
    chk("t5_out_cnt", DW'(outc0), 9);
    chk("t5_slip_cnt", DW'(slip0), 1);

    // 6) reset with three packets in flight
    do_reset();
    for (int i = 0; i < 3; i++) send(DW'(300 + i), 1'b0, '0, 3, -1);
    chk("t6_pre_in_cnt", DW'(inc0), 3);
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk("t6_rst_vld", DW'(vld0), 0);
    chk("t6_rst_data", data0, 0);
    chk("t6_rst_in_cnt", DW'(inc0), 0);
    chk("t6_rst_rdy", DW'(rdy0), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_post_out_cnt", DW'(outc0), 0);
    chk("t6_post_vld", DW'(vld0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
